// File: rtl/param_alu_if.sv
// param_alu_if: command/result bus between the host sequencer and param_alu.
//   master : host side, drives start/opcode/rd_sel/rs_sel/input_data,
//            observes busy/done/result_upper/result_lower/flag_{z,n,c,v}.
//   slave  : ALU side, the mirror image.
interface param_alu_if #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
);
  localparam int SELW = $clog2(NREGS);

  logic             start;
  logic [4:0]       opcode;
  logic [SELW-1:0]  rd_sel;
  logic [SELW-1:0]  rs_sel;
  logic [WIDTH-1:0] input_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_upper;
  logic [WIDTH-1:0] result_lower;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;

  modport master (
    output start, opcode, rd_sel, rs_sel, input_data,
    input  busy, done, result_upper, result_lower,
           flag_z, flag_n, flag_c, flag_v
  );

  modport slave (
    input  start, opcode, rd_sel, rs_sel, input_data,
    output busy, done, result_upper, result_lower,
           flag_z, flag_n, flag_c, flag_v
  );
endinterface

// File: rtl/param_alu.sv
// param_alu: WIDTH-bit register-file ALU with start/busy/done handshake.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : param_alu_if.slave (command in, results/flags out, all registered)
// Single-cycle ops complete at the accepting edge; signed MULT runs a
// WIDTH-step shift-add engine and writes the high word to R[rd] and the
// low word to R[rd+1] (wrapping).
module param_alu #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
) (
  input  logic           clk,
  input  logic           rst,
  param_alu_if.slave     bus
);
  localparam int SELW = $clog2(NREGS);
  localparam int SHW  = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  localparam logic [4:0] OP_ADD = 5'h00, OP_SUB = 5'h01, OP_MULT = 5'h02,
                         OP_AND = 5'h03, OP_OR  = 5'h04, OP_XOR  = 5'h05,
                         OP_NOT = 5'h06, OP_LSL = 5'h07, OP_LSR  = 5'h08,
                         OP_ASR = 5'h09, OP_ROL = 5'h0A, OP_ROR  = 5'h0B,
                         OP_LOAD = 5'h0C, OP_READ = 5'h0D, OP_RDPAIR = 5'h0E;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t                       r_state;
  logic [NREGS-1:0][WIDTH-1:0]  r_regs;
  logic                         r_busy, r_done;
  logic [WIDTH-1:0]             r_ru, r_rl;
  logic                         r_z, r_n, r_c, r_v;
  logic [2*WIDTH-1:0]           r_acc, r_mcand;
  logic [WIDTH-1:0]             r_mplier;
  logic [SHW-1:0]               r_cnt;
  logic [SELW-1:0]              r_rd;

  logic [WIDTH-1:0]   w_a, w_b, w_res;
  logic [SHW-1:0]     w_sh;
  logic [2*WIDTH-1:0] w_rot, w_pp, w_acc_nx;
  logic               w_c, w_v, w_wr, w_arith, w_last;

  assign w_a  = r_regs[bus.rd_sel];
  assign w_b  = r_regs[bus.rs_sel];
  assign w_sh = w_b[SHW-1:0];

  always_comb begin
    w_res   = '0;
    w_rot   = '0;
    w_c     = 1'b0;
    w_v     = 1'b0;
    w_wr    = 1'b1;
    w_arith = 1'b0;
    case (bus.opcode)
      OP_ADD: begin
        {w_c, w_res} = {1'b0, w_a} + {1'b0, w_b};
        w_v     = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_res[WIDTH-1] != w_a[WIDTH-1]);
        w_arith = 1'b1;
      end
      OP_SUB: begin
        w_res   = w_a - w_b;
        w_c     = (w_a < w_b);
        w_v     = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_res[WIDTH-1] != w_a[WIDTH-1]);
        w_arith = 1'b1;
      end
      OP_AND:  w_res = w_a & w_b;
      OP_OR:   w_res = w_a | w_b;
      OP_XOR:  w_res = w_a ^ w_b;
      OP_NOT:  w_res = ~w_a;
      OP_LSL:  w_res = w_a << w_sh;
      OP_LSR:  w_res = w_a >> w_sh;
      OP_ASR:  w_res = WIDTH'($signed(w_a) >>> w_sh);
      // Rotates shift a doubled copy so sh=0 falls out naturally.
      OP_ROL: begin
        w_rot = {w_a, w_a} << w_sh;
        w_res = w_rot[2*WIDTH-1:WIDTH];
      end
      OP_ROR: begin
        w_rot = {w_a, w_a} >> w_sh;
        w_res = w_rot[WIDTH-1:0];
      end
      OP_LOAD: w_res = bus.input_data;
      default: w_wr = 1'b0;  // MULT, reads and illegal codes handled separately
    endcase
  end

  // Shift-add step; the multiplier MSB carries negative weight, so the
  // final partial product is subtracted instead of added.
  assign w_last   = (r_cnt == CNT_LAST);
  assign w_pp     = r_mplier[0] ? r_mcand : '0;
  assign w_acc_nx = w_last ? (r_acc - w_pp) : (r_acc + w_pp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_regs   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ru     <= '0;
      r_rl     <= '0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_rd     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            case (bus.opcode)
              OP_MULT: begin
                r_acc    <= '0;
                r_mcand  <= {{WIDTH{w_a[WIDTH-1]}}, w_a};
                r_mplier <= w_b;
                r_cnt    <= '0;
                r_rd     <= bus.rd_sel;
                r_busy   <= 1'b1;
                r_state  <= S_MUL;
              end
              OP_READ: begin
                r_ru   <= '0;
                r_rl   <= w_b;
                r_done <= 1'b1;
              end
              OP_RDPAIR: begin
                r_ru   <= w_a;
                r_rl   <= w_b;
                r_done <= 1'b1;
              end
              default: begin
                if (w_wr) begin
                  r_regs[bus.rd_sel] <= w_res;
                  r_ru <= '0;
                  r_rl <= w_res;
                  r_z  <= (w_res == '0);
                  r_n  <= w_res[WIDTH-1];
                  r_c  <= w_arith & w_c;
                  r_v  <= w_arith & w_v;
                end
                r_done <= 1'b1;
              end
            endcase
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_nx;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_regs[r_rd]                <= w_acc_nx[2*WIDTH-1:WIDTH];
            r_regs[SELW'(r_rd + 1'b1)]  <= w_acc_nx[WIDTH-1:0];
            r_ru    <= w_acc_nx[2*WIDTH-1:WIDTH];
            r_rl    <= w_acc_nx[WIDTH-1:0];
            r_z     <= (w_acc_nx == '0);
            r_n     <= w_acc_nx[2*WIDTH-1];
            r_c     <= 1'b0;
            r_v     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.result_upper = r_ru;
  assign bus.result_lower = r_rl;
  assign bus.flag_z       = r_z;
  assign bus.flag_n       = r_n;
  assign bus.flag_c       = r_c;
  assign bus.flag_v       = r_v;
endmodule

// File: tb/tb_param_alu.sv
// tb_param_alu: directed + random checks of param_alu (WIDTH=8, NREGS=4)
// against an integer-arithmetic reference model.
module tb_param_alu;
  localparam int W    = 8;
  localparam int N    = 4;
  localparam int SELW = $clog2(N);
  localparam int M    = (1 << W) - 1;
  localparam int SMAX = (1 << (W - 1)) - 1;
  localparam int SMIN = -(1 << (W - 1));

  logic clk = 1'b0;
  logic rst = 1'b1;

  param_alu_if #(.WIDTH(W), .NREGS(N)) bus ();
  param_alu #(.WIDTH(W), .NREGS(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  int m_r[N];
  int m_ru, m_rl;
  bit m_z, m_n, m_c, m_v;

  function automatic int sx(int v);
    return (v > SMAX) ? v - (1 << W) : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_r[i] = 0;
    m_ru = 0; m_rl = 0;
    m_z = 0; m_n = 0; m_c = 0; m_v = 0;
  endtask

  task automatic model(int op, int rd, int rs, int din);
    int a = m_r[rd];
    int b = m_r[rs];
    int sh = b % W;
    int res = 0;
    int s;
    int p;
    bit wr = 1;
    bit arith = 0;
    case (op)
      0: begin
        s = a + b; res = s & M; m_c = (s > M);
        s = sx(a) + sx(b); m_v = (s > SMAX) || (s < SMIN); arith = 1;
      end
      1: begin
        res = (a - b) & M; m_c = (a < b);
        s = sx(a) - sx(b); m_v = (s > SMAX) || (s < SMIN); arith = 1;
      end
      2: begin
        p = (sx(a) * sx(b)) & ((1 << (2 * W)) - 1);
        m_r[rd] = p >> W;
        m_r[(rd + 1) % N] = p & M;
        m_ru = p >> W; m_rl = p & M;
        m_z = (p == 0); m_n = p[2*W-1]; m_c = 0; m_v = 0;
        wr = 0;
      end
      3:  res = a & b;
      4:  res = a | b;
      5:  res = a ^ b;
      6:  res = (~a) & M;
      7:  res = (a << sh) & M;
      8:  res = a >> sh;
      9:  res = (sx(a) >>> sh) & M;
      10: res = ((a << sh) | (a >> (W - sh))) & M;
      11: res = ((a >> sh) | (a << (W - sh))) & M;
      12: res = din & M;
      13: begin m_ru = 0; m_rl = b; wr = 0; end
      14: begin m_ru = a; m_rl = b; wr = 0; end
      default: wr = 0;
    endcase
    if (wr) begin
      m_r[rd] = res;
      m_ru = 0; m_rl = res;
      m_z = (res == 0); m_n = res[W-1];
      if (!arith) begin m_c = 0; m_v = 0; end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic chk_out(string tag);
    chk({tag, "_done"}, bus.done, 1);
    chk({tag, "_upper"}, bus.result_upper, m_ru);
    chk({tag, "_lower"}, bus.result_lower, m_rl);
    chk({tag, "_flags"}, {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v},
        {m_z, m_n, m_c, m_v});
  endtask

  task automatic drive(int op, int rd, int rs, int din);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.opcode     = 5'(op);
    bus.rd_sel     = SELW'(rd);
    bus.rs_sel     = SELW'(rs);
    bus.input_data = W'(din);
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Issue one command, update the model, wait out a multiply (poking
  // ignored commands and operand changes at it meanwhile), then check.
  task automatic run(string tag, int op, int rd, int rs, int din);
    drive(op, rd, rs, din);
    model(op, rd, rs, din);
    if (op == 2) begin
      int n = 0;
      chk({tag, "_busy"}, bus.busy, 1);
      while (bus.done !== 1'b1 && n < 3 * W) begin
        @(negedge clk);
        if (n == 1 || n == W - 2) begin
          bus.start      = 1'b1;
          bus.opcode     = 5'h0C;
          bus.rd_sel     = SELW'($urandom);
          bus.rs_sel     = SELW'($urandom);
          bus.input_data = W'($urandom);
        end
        @(posedge clk);
        #1 bus.start = 1'b0;
        n++;
      end
      chk({tag, "_latency"}, n, W);
      chk({tag, "_busy_end"}, bus.busy, 0);
    end
    chk_out(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int op, rd, rs, pick;
    bus.start = 1'b0; bus.opcode = '0; bus.rd_sel = '0;
    bus.rs_sel = '0; bus.input_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_results", {bus.result_upper, bus.result_lower}, 0);
    chk("rst_flags", {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}, 0);
    @(negedge clk) rst = 1'b0;

    // ADD overflow 7F+01
    run("ld0", 12, 0, 0, 'h7F);
    run("ld1", 12, 1, 0, 'h01);
    run("add", 0, 0, 1, 0);
    chk("add_val", bus.result_lower, 'h80);
    chk("add_zncv", {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}, 4'b0101);
    @(posedge clk); #1;
    chk("add_done_drop", bus.done, 0);

    // SUB borrow, then SUB to zero
    run("ld0b", 12, 0, 0, 'h00);
    run("ld1b", 12, 1, 0, 'h01);
    run("sub", 1, 0, 1, 0);
    chk("sub_val", bus.result_lower, 'hFF);
    chk("sub_zncv", {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}, 4'b0110);
    run("ld0c", 12, 0, 0, 'h05);
    run("ld1c", 12, 1, 0, 'h05);
    run("subz", 1, 0, 1, 0);
    chk("subz_zncv", {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}, 4'b1000);

    // MULT -3 * 5
    run("ld0d", 12, 0, 0, 'hFD);
    run("ld1d", 12, 1, 0, 'h05);
    run("mul", 2, 0, 1, 0);
    chk("mul_res", {bus.result_upper, bus.result_lower}, 'hFFF1);
    chk("mul_n", bus.flag_n, 1);
    run("mul_rp", 14, 0, 1, 0);
    chk("mul_regs", {bus.result_upper, bus.result_lower}, 'hFFF1);

    // MULT -128 squared, rd=3 wraps low word into R0
    run("ld3", 12, 3, 0, 'h80);
    run("sq", 2, 3, 3, 0);
    chk("sq_res", {bus.result_upper, bus.result_lower}, 'h4000);
    run("sq_rp", 14, 3, 0, 0);
    chk("sq_regs", {bus.result_upper, bus.result_lower}, 'h4000);

    // Rotates and shifts
    run("ld2", 12, 2, 0, 'h81);
    run("ld3b", 12, 3, 0, 'h01);
    run("rol", 10, 2, 3, 0);
    chk("rol_val", bus.result_lower, 'h03);
    run("ld2b", 12, 2, 0, 'h81);
    run("ld3c", 12, 3, 0, 'h08);
    run("ror0", 11, 2, 3, 0);
    chk("ror0_val", bus.result_lower, 'h81);
    run("ld3d", 12, 3, 0, 'h01);
    run("asr", 9, 2, 3, 0);
    chk("asr_val", bus.result_lower, 'hC0);
    run("ld2c", 12, 2, 0, 'h81);
    run("lsr", 8, 2, 3, 0);
    chk("lsr_val", bus.result_lower, 'h40);

    // Illegal opcode and plain READ
    run("illegal", 15, 1, 2, 'h33);
    run("read", 13, 0, 2, 0);
    chk("read_val", {bus.result_upper, bus.result_lower}, 'h0040);

    // Random traffic against the model
    for (int i = 0; i < 200; i++) begin
      pick = $urandom_range(0, 19);
      op   = (pick <= 14) ? pick : $urandom_range(15, 31);
      rd   = $urandom_range(0, N - 1);
      rs   = $urandom_range(0, N - 1);
      run($sformatf("rnd%0d_op%0h", i, op), op, rd, rs, $urandom_range(0, M));
    end

    // Reset in the middle of a multiply
    run("ld0e", 12, 0, 0, 'h37);
    drive(2, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_done", bus.done, 0);
    chk("mrst_results", {bus.result_upper, bus.result_lower}, 0);
    chk("mrst_flags", {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}, 0);
    @(negedge clk) rst = 1'b0;
    run("mrst_rp01", 14, 0, 1, 0);
    chk("mrst_r01", {bus.result_upper, bus.result_lower}, 0);
    run("mrst_rp23", 14, 2, 3, 0);
    chk("mrst_r23", {bus.result_upper, bus.result_lower}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/param_alu.md
Name: param_alu

Overview:
- Parametrised successor to the team's 8-bit accumulator ALU: WIDTH-bit datapath, NREGS-entry register file, start/busy/done command handshake, registered status flags.
- Single-cycle logic/arith/shift ops; signed multiply is a multi-cycle shift-add engine, so wide configurations close timing.
- Sits between the host command sequencer and the register/readback path; results are registered, never combinational from opcode.

Parameters:
- WIDTH, 8, datapath width; power of two, >= 4.
- NREGS, 4, register-file depth; power of two, >= 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  command valid; accepted only when busy=0.
- opcode  in  5  operation, encodings below.
- rd_sel  in  log2(NREGS)  destination / first operand index.
- rs_sel  in  log2(NREGS)  second operand / read index.
- input_data  in  WIDTH  load data.
- busy  out  1  multiply in progress; commands ignored.
- done  out  1  one-cycle pulse, command complete.
- result_upper  out  WIDTH  upper result word.
- result_lower  out  WIDTH  lower result word.
- flag_z  out  1  zero.
- flag_n  out  1  negative (MSB of written value).
- flag_c  out  1  carry (ADD) / borrow (SUB).
- flag_v  out  1  signed overflow (ADD/SUB).

Behaviour:
- Reset (async): all R[i]=0, FSM IDLE, busy=0, done=0, results=0, flags=0. Reset mid-multiply aborts it; no partial write.
- Opcodes: 00 ADD, 01 SUB, 02 MULT, 03 AND, 04 OR, 05 XOR, 06 NOT, 07 LSL, 08 LSR, 09 ASR, 0A ROL, 0B ROR, 0C LOAD, 0D READ, 0E READ_PAIR. 0F-1F illegal.
- Notation: A=R[rd_sel], B=R[rs_sel], sh=B[log2(WIDTH)-1:0]. ALU ops write R[rd_sel]<=A op B. NOT: ~A. LOAD: R[rd_sel]<=input_data.
- Accept: rising edge with start=1, busy=0 (edge k). Start while busy=1 is dropped; nothing queued.
- Single-cycle ops: at edge k write reg, result_lower=new value, result_upper=0, update flags. done=1 for cycle k..k+1.
- READ: result_lower=B, result_upper=0. READ_PAIR: result_upper=A, result_lower=B. Reads: no reg write, flags unchanged.
- Illegal: done pulses; regs, results and flags unchanged.
- Flags:
  - Z and N update on every register-writing op.
  - ADD: C=carry-out, V=signed overflow.
  - SUB: C=1 on unsigned borrow (A<B), V=signed overflow.
  - Non-arith ops clear C and V.
- Shifts: sh in 0..WIDTH-1. LSL/LSR zero-fill. ASR sign-fill. ROL/ROR: sh=0 leaves value unchanged.
- MULT FSM IDLE->MUL->IDLE:
  - At edge k latch operands and rd_sel, busy<=1.
  - One partial-product step per edge; signed (two's complement) 2*WIDTH-bit product.
  - At edge k+WIDTH: R[rd]<=P[2W-1:W], R[(rd+1) mod NREGS]<=P[W-1:0], result_upper/lower=P halves, busy<=0, done<=1, Z=(P==0), N=P[2W-1], C=V=0.
  - Latency WIDTH cycles.
  - Operands are snapshotted; rd_sel/rs_sel/opcode changes during busy have no effect.
  - rd=rs (square) is legal.
- Back-to-back: new start accepted in the same cycle done is high for single-cycle ops, and on the first edge after busy falls.

Test Plan:
- WIDTH=8. LOAD R0=7F, R1=01; ADD rd=0 rs=1 -> R0=80, done one cycle, N=1 V=1 C=0 Z=0.
- LOAD R0=00, R1=01; SUB -> R0=FF, C=1 N=1 V=0. Then SUB with R0=R1=05 -> Z=1, C=0.
- R0=FD(-3), R1=05; MULT rd=0 -> busy 8 cycles; R0=FF, R1=F1, results FF/F1, N=1; start pulses during busy ignored.
- MULT 80*80 (-128*-128) -> 4000; rd=3 wraps low word into R0.
- R2=81, R3=01: ROL -> 03; ROR with R3=08 (sh=0) -> unchanged; ASR 81 by 1 -> C0; LSR -> 40.
- Start MULT, assert rst at cycle 4 -> busy=0, done=0, all regs 0; READ_PAIR after reset -> 00/00.
